// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the machine-mode system controller: CSR addresses,
// trap cause codes, mstatus/mie/mip bit positions and the sequencer state.
package sys_ctrl_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;

    // Exception codes; the interrupt code is combined with the XLEN-1 interrupt flag.
    localparam int unsigned CAUSE_ILLEGAL  = 2;
    localparam int unsigned CAUSE_BREAK    = 3;
    localparam int unsigned CAUSE_ECALL    = 11;
    localparam int unsigned CAUSE_MEXT_IRQ = 11;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;
    localparam int MIE_MEIE       = 11;
    localparam int MIP_MEIP       = 11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TRAP,
        ST_WFI
    } state_e;

    typedef enum logic [1:0] {
        CSR_OP_RW,
        CSR_OP_RS,
        CSR_OP_RC
    } csr_op_e;

endpackage

// File: rtl/sys_ctrl_csr_regs.sv
// Machine-mode CSR storage, read mux and read-modify-write arithmetic.
// Optional SYS_CTRL_MCYCLE_EN adds a free-running, writable mcycle at 0xB00.
module sys_csr_regs
    import sys_ctrl_pkg::*;
#(
    parameter int              XLEN        = 64,
    parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            irq_ext_i,
    input  logic [11:0]     addr_i,
    input  logic            op_en_i,
    input  csr_op_e         op_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic            rs1_zero_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_epc_i,
    input  logic [XLEN-1:0] trap_cause_i,
    input  logic            mret_i,
    output logic [XLEN-1:0] rdata_o,
    output logic            addr_ok_o,
    output logic [XLEN-1:0] mtvec_o,
    output logic [XLEN-1:0] mepc_o,
    output logic            mstatus_mie_o,
    output logic            mie_meie_o
);

    localparam logic [XLEN-1:0] ALIGN4 = {{(XLEN-2){1'b1}}, 2'b00};

    logic            mie_q, mie_d;
    logic            mpie_q, mpie_d;
    logic            meie_q, meie_d;
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
`ifdef SYS_CTRL_MCYCLE_EN
    logic [XLEN-1:0] mcycle_q, mcycle_d;
`endif

    logic [XLEN-1:0] rdata;
    logic            addr_ok;
    logic [XLEN-1:0] wdata;
    logic            we;

    always_comb begin
        rdata   = '0;
        addr_ok = 1'b1;
        case (addr_i)
            CSR_MSTATUS: begin
                rdata[MSTATUS_MIE]                   = mie_q;
                rdata[MSTATUS_MPIE]                  = mpie_q;
                rdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
            end
            CSR_MIE:      rdata[MIE_MEIE] = meie_q;
            CSR_MTVEC:    rdata = mtvec_q;
            CSR_MSCRATCH: rdata = mscratch_q;
            CSR_MEPC:     rdata = mepc_q;
            CSR_MCAUSE:   rdata = mcause_q;
            CSR_MIP:      rdata[MIP_MEIP] = irq_ext_i;
`ifdef SYS_CTRL_MCYCLE_EN
            CSR_MCYCLE:   rdata = mcycle_q;
`endif
            default:      addr_ok = 1'b0;
        endcase
    end

    // Set/clear with rs1 = x0 is a pure read and must not disturb the CSR.
    always_comb begin
        case (op_i)
            CSR_OP_RS: wdata = rdata | rs1_data_i;
            CSR_OP_RC: wdata = rdata & ~rs1_data_i;
            default:   wdata = rs1_data_i;
        endcase
        we = op_en_i & addr_ok & ((op_i == CSR_OP_RW) | ~rs1_zero_i);
    end

    always_comb begin
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        meie_d     = meie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        if (trap_i) begin
            mepc_d   = trap_epc_i & ALIGN4;
            mcause_d = trap_cause_i;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end else if (mret_i) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end else if (we) begin
            case (addr_i)
                CSR_MSTATUS: begin
                    mie_d  = wdata[MSTATUS_MIE];
                    mpie_d = wdata[MSTATUS_MPIE];
                end
                CSR_MIE:      meie_d     = wdata[MIE_MEIE];
                CSR_MTVEC:    mtvec_d    = wdata & ALIGN4;
                CSR_MSCRATCH: mscratch_d = wdata;
                CSR_MEPC:     mepc_d     = wdata & ALIGN4;
                CSR_MCAUSE:   mcause_d   = wdata;
                default:      ;
            endcase
        end
    end

`ifdef SYS_CTRL_MCYCLE_EN
    // A software write replaces, rather than adds to, this cycle's increment.
    always_comb begin
        mcycle_d = mcycle_q + XLEN'(1);
        if (we && addr_i == CSR_MCYCLE) begin
            mcycle_d = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcycle_q <= '0;
        end else begin
            mcycle_q <= mcycle_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            meie_q     <= 1'b0;
            mtvec_q    <= MTVEC_RESET & ALIGN4;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
        end else begin
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            meie_q     <= meie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
        end
    end

    assign rdata_o       = rdata;
    assign addr_ok_o     = addr_ok;
    assign mtvec_o       = mtvec_q;
    assign mepc_o        = mepc_q;
    assign mstatus_mie_o = mie_q;
    assign mie_meie_o    = meie_q;

endmodule

// File: rtl/sys_ctrl.sv
// Machine-mode system op sequencer: CSR ops, ecall/ebreak/mret/wfi, trap entry
// and front-end redirect. SYS_CTRL_MCYCLE_EN enables the mcycle CSR.
module sys_ctrl
    import sys_ctrl_pkg::*;
#(
    parameter int              XLEN        = 64,
    parameter logic [XLEN-1:0] MTVEC_RESET = 64'h0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            op_valid,
    output logic            op_ready,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic            rs1_zero,
    input  logic            ecall_op,
    input  logic            ebreak_op,
    input  logic            mret_op,
    input  logic            wfi_op,
    input  logic            csrrw_op,
    input  logic            csrrs_op,
    input  logic            csrrc_op,
    input  logic [11:0]     csr_addr,
    input  logic            irq_ext,
    output logic            rd_valid,
    output logic [XLEN-1:0] rd_data,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc
);

    localparam logic [XLEN-1:0] IRQ_CAUSE = {1'b1, {(XLEN-1){1'b0}}} | XLEN'(CAUSE_MEXT_IRQ);

    state_e          state_q, state_d;
    logic            rd_valid_q, rd_valid_d;
    logic [XLEN-1:0] rd_data_q, rd_data_d;
    logic            redirect_q, redirect_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic [XLEN-1:0] wfi_pc_q, wfi_pc_d;

    logic            csr_en, trap_en, mret_en;
    logic [XLEN-1:0] trap_epc, trap_cause;
    csr_op_e         csr_op;
    logic [XLEN-1:0] csr_rdata, mtvec, mepc;
    logic            csr_addr_ok, mstatus_mie, mie_meie;

    logic [6:0] op_bits;
    logic       multi_op, is_csr, accept, irq_pend, wake;

    assign op_bits  = {ecall_op, ebreak_op, mret_op, wfi_op, csrrw_op, csrrs_op, csrrc_op};
    assign multi_op = |(op_bits & (op_bits - 7'd1));
    assign is_csr   = csrrw_op | csrrs_op | csrrc_op;
    assign accept   = op_valid & op_ready;
    assign wake     = irq_ext & mie_meie;
    assign irq_pend = wake & mstatus_mie;
    assign csr_op   = csrrw_op ? CSR_OP_RW : (csrrs_op ? CSR_OP_RS : CSR_OP_RC);

    sys_csr_regs #(
        .XLEN        (XLEN),
        .MTVEC_RESET (MTVEC_RESET)
    ) u_csr (
        .clk           (clk),
        .rst           (rst),
        .irq_ext_i     (irq_ext),
        .addr_i        (csr_addr),
        .op_en_i       (csr_en),
        .op_i          (csr_op),
        .rs1_data_i    (rs1_data),
        .rs1_zero_i    (rs1_zero),
        .trap_i        (trap_en),
        .trap_epc_i    (trap_epc),
        .trap_cause_i  (trap_cause),
        .mret_i        (mret_en),
        .rdata_o       (csr_rdata),
        .addr_ok_o     (csr_addr_ok),
        .mtvec_o       (mtvec),
        .mepc_o        (mepc),
        .mstatus_mie_o (mstatus_mie),
        .mie_meie_o    (mie_meie)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            rd_valid_q    <= 1'b0;
            rd_data_q     <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            wfi_pc_q      <= '0;
        end else begin
            state_q       <= state_d;
            rd_valid_q    <= rd_valid_d;
            rd_data_q     <= rd_data_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            wfi_pc_q      <= wfi_pc_d;
        end
    end

    // A pending interrupt outranks whatever op is presented; the op is dropped.
    always_comb begin
        state_d       = state_q;
        rd_valid_d    = 1'b0;
        rd_data_d     = rd_data_q;
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc_q;
        wfi_pc_d      = wfi_pc_q;
        csr_en        = 1'b0;
        trap_en       = 1'b0;
        mret_en       = 1'b0;
        trap_epc      = pc;
        trap_cause    = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (irq_pend) begin
                        trap_en    = 1'b1;
                        trap_cause = IRQ_CAUSE;
                    end else if (multi_op || (is_csr && !csr_addr_ok)) begin
                        trap_en    = 1'b1;
                        trap_cause = XLEN'(CAUSE_ILLEGAL);
                    end else if (ecall_op) begin
                        trap_en    = 1'b1;
                        trap_cause = XLEN'(CAUSE_ECALL);
                    end else if (ebreak_op) begin
                        trap_en    = 1'b1;
                        trap_cause = XLEN'(CAUSE_BREAK);
                    end else if (mret_op) begin
                        mret_en       = 1'b1;
                        redirect_d    = 1'b1;
                        redirect_pc_d = mepc;
                    end else if (wfi_op) begin
                        state_d  = ST_WFI;
                        wfi_pc_d = pc;
                    end else if (is_csr) begin
                        csr_en     = 1'b1;
                        rd_valid_d = 1'b1;
                        rd_data_d  = csr_rdata;
                    end
                    if (trap_en) begin
                        state_d       = ST_TRAP;
                        redirect_d    = 1'b1;
                        redirect_pc_d = mtvec;
                    end
                end
            end
            ST_WFI: begin
                // Both wake paths spend one TRAP cycle issuing the redirect.
                if (wake) begin
                    state_d    = ST_TRAP;
                    redirect_d = 1'b1;
                    if (mstatus_mie) begin
                        trap_en       = 1'b1;
                        trap_epc      = wfi_pc_q + XLEN'(4);
                        trap_cause    = IRQ_CAUSE;
                        redirect_pc_d = mtvec;
                    end else begin
                        redirect_pc_d = wfi_pc_q + XLEN'(4);
                    end
                end
            end
            ST_TRAP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        op_ready = (state_q == ST_IDLE);
    end

    assign rd_valid    = rd_valid_q;
    assign rd_data     = rd_data_q;
    assign redirect    = redirect_q;
    assign redirect_pc = redirect_pc_q;

endmodule
